// File: rtl/ug_pkg.sv
// Shared types and helpers for the universal-gate exerciser: FSM state encoding,
// vector constants and the golden NAND/NOR model.
package ug_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } ug_state_e;

  localparam int         VEC_W    = 2;
  localparam logic [1:0] LAST_VEC = 2'd3;

  // Returns {nand, nor} for the given input pair.
  function automatic logic [1:0] ug_expect(input logic a, input logic b);
    return {~(a & b), ~(a | b)};
  endfunction

endpackage

// File: rtl/ug_settle_timer.sv
// Settle-time down-counter: loaded with SETTLE_CYCLES, expires on its last cycle.
// Collapses to a constant expire when SETTLE_CYCLES is 0.
module ug_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  if (SETTLE_CYCLES == 0) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, load_i, en_i};
    assign expire_o      = 1'b1;
  end else begin : g_cnt
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (load_i)
        cnt_d = CW'(SETTLE_CYCLES);
      else if (en_i && (cnt_q != '0))
        cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    // Terminal count at 1 so the last SETTLE cycle itself raises expire.
    assign expire_o = (cnt_q == CW'(1));
  end

endmodule

// File: rtl/universal_gate_exerciser.sv
// Stimulus/check harness for a NAND/NOR gate pair: sweeps all four input vectors,
// waits a settle time, compares against golden values. Optional first-error capture
// is enabled by defining UG_FIRST_ERR_EN.
module universal_gate_exerciser
  import ug_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             obs_nand,
  input  logic             obs_nor,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef UG_FIRST_ERR_EN
  output logic [VEC_W-1:0] first_err_vec,
  output logic             first_err_valid,
`endif
  output logic [ERR_W-1:0] err_cnt
);

  ug_state_e        state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [VEC_W-1:0] drv_q, drv_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             settle_load, settle_en, settle_expire;
  logic [1:0]       golden;
  logic             mismatch;
`ifdef UG_FIRST_ERR_EN
  logic [VEC_W-1:0] fev_q, fev_d;
  logic             fvalid_q, fvalid_d;
`endif

  ug_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (settle_load),
    .en_i     (settle_en),
    .expire_o (settle_expire)
  );

  assign golden   = ug_expect(vec_q[1], vec_q[0]);
  assign mismatch = (obs_nand != golden[1]) | (obs_nor != golden[0]);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    drv_d       = drv_q;
    err_d       = err_q;
    pass_d      = pass_q;
    settle_load = 1'b0;
    settle_en   = 1'b0;
`ifdef UG_FIRST_ERR_EN
    fev_d       = fev_q;
    fvalid_d    = fvalid_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          drv_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef UG_FIRST_ERR_EN
          fev_d    = '0;
          fvalid_d = 1'b0;
`endif
        end
      end
      DRIVE: begin
        settle_load = 1'b1;
        if (SETTLE_CYCLES > 0) state_d = SETTLE;
        else                   state_d = CHECK;
      end
      SETTLE: begin
        settle_en = 1'b1;
        if (settle_expire) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
`ifdef UG_FIRST_ERR_EN
          if (!fvalid_q) begin
            fev_d    = vec_q;
            fvalid_d = 1'b1;
          end
`endif
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + 1'b1;
          drv_d   = vec_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      drv_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
`ifdef UG_FIRST_ERR_EN
      fev_q    <= '0;
      fvalid_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      drv_q    <= drv_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
`ifdef UG_FIRST_ERR_EN
      fev_q    <= fev_d;
      fvalid_q <= fvalid_d;
`endif
    end
  end

  assign drv_a   = drv_q[1];
  assign drv_b   = drv_q[0];
  assign busy    = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == CHECK);
  assign done    = (state_q == DONE);
  assign pass    = pass_q;
  assign err_cnt = err_q;
`ifdef UG_FIRST_ERR_EN
  assign first_err_vec   = fev_q;
  assign first_err_valid = fvalid_q;
`endif

endmodule
